// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity types, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Default frame geometry
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 8;

  // Parity type select values for PAR_TYP
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Receiver frame states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // 2-of-3 majority used to reject single-sample noise
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter plus 3-sample majority vote around mid-bit.
// Latency: majority valid one cycle after the third sample (edge_cnt = PRESCALE/2+1).
// Backpressure: none; runs freely while run is high, held at zero otherwise.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_s,
  input  logic run,
  output logic sampled_bit,
  output logic sample_valid,
  output logic bit_done
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] SMP_0    = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SMP_1    = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] SMP_2    = CW'(PRESCALE / 2 + 1);

  logic [CW-1:0] edge_cnt;
  logic          smp_a;
  logic          smp_b;

  // Position within the current bit period; cleared whenever the receiver is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
    end else if (edge_cnt == CNT_LAST) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + CW'(1);
    end
  end

  // Capture the first two mid-bit samples; vote with the third as it arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_a        <= 1'b1;
      smp_b        <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= run && (edge_cnt == SMP_2);
      if (run && (edge_cnt == SMP_0)) begin
        smp_a <= rx_s;
      end
      if (run && (edge_cnt == SMP_1)) begin
        smp_b <= rx_s;
      end
      if (run && (edge_cnt == SMP_2)) begin
        sampled_bit <= maj3(smp_a, smp_b, rx_s);
      end
    end
  end

  assign bit_done = run && (edge_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, width data bits LSB first, optional parity, one stop bit.
// Latency: 2-cycle input synchroniser; result pulses one cycle after stop-bit majority.
// Backpressure: none; the consumer must take P_DATA_RX on the DATA_VALID_RX pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int width    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             CLK_RX,
  input  logic             RST_RX,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [width-1:0] P_DATA_RX,
  output logic             DATA_VALID_RX,
  output logic             PAR_ERR,
  output logic             STP_ERR,
  output logic             Busy
);

  localparam int BW = (width > 1) ? $clog2(width) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);

  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [width-1:0] shift_q;
  logic             par_en_q;
  logic             par_typ_q;
  logic             par_bad;
  logic             exp_par;
  logic             start_seen;
  logic             sampled_bit;
  logic             sample_valid;
  logic             bit_done;

  // Two-flop synchroniser; idles high so reset never looks like a start edge
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk         (CLK_RX),
    .rst_n       (RST_RX),
    .rx_s        (rx_s),
    .run         (state != ST_IDLE),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid),
    .bit_done    (bit_done)
  );

  assign start_seen = (state == ST_IDLE) && !rx_s;
  assign exp_par    = (^shift_q) ^ (par_typ_q == PAR_ODD);
  assign Busy       = (state != ST_IDLE);

  // Frame state register
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: bit-to-bit moves on bit_done, START/STOP decisions on the vote
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch on an idle line
        if (sample_valid && sampled_bit) begin
          state_nxt = ST_IDLE;
        end else if (bit_done) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done && (bit_cnt == BIT_LAST)) begin
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed
        if (sample_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame datapath: per-frame config latch, shift register, parity and result pulses
  always_ff @(posedge CLK_RX or negedge RST_RX) begin
    if (!RST_RX) begin
      bit_cnt       <= '0;
      shift_q       <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= PAR_EVEN;
      par_bad       <= 1'b0;
      P_DATA_RX     <= '0;
      DATA_VALID_RX <= 1'b0;
      PAR_ERR       <= 1'b0;
      STP_ERR       <= 1'b0;
    end else begin
      DATA_VALID_RX <= 1'b0;
      PAR_ERR       <= 1'b0;
      STP_ERR       <= 1'b0;

      // Parity configuration is frozen for the whole frame at the start edge
      if (start_seen) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_bad   <= 1'b0;
        bit_cnt   <= '0;
      end

      case (state)
        ST_DATA: begin
          if (sample_valid) begin
            shift_q[bit_cnt] <= sampled_bit;
          end
          if (bit_done) begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_PARITY: begin
          if (sample_valid) begin
            par_bad <= (sampled_bit != exp_par);
          end
        end
        ST_STOP: begin
          // Stop error outranks parity error; the word is only published when clean
          if (sample_valid) begin
            if (!sampled_bit) begin
              STP_ERR <= 1'b1;
            end else if (par_bad) begin
              PAR_ERR <= 1'b1;
            end else begin
              P_DATA_RX     <= shift_q;
              DATA_VALID_RX <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames.
// Expected results come from frame-level rules (parity by popcount, stop/parity priority).
// Observed pulses are recorded by a monitor and compared against a scoreboard queue.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int W = 8;
  localparam int P = 8;

  logic         CLK_RX = 1'b0;
  logic         RST_RX = 1'b0;
  logic         RX_IN = 1'b1;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [W-1:0] P_DATA_RX;
  logic         DATA_VALID_RX;
  logic         PAR_ERR;
  logic         STP_ERR;
  logic         Busy;

  uart_rx #(
    .width(W),
    .PRESCALE(P)
  ) dut (
    .CLK_RX       (CLK_RX),
    .RST_RX       (RST_RX),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .P_DATA_RX    (P_DATA_RX),
    .DATA_VALID_RX(DATA_VALID_RX),
    .PAR_ERR      (PAR_ERR),
    .STP_ERR      (STP_ERR),
    .Busy         (Busy)
  );

  always #5 CLK_RX = ~CLK_RX;

  int checks = 0;
  int errors = 0;

  // Observed activity
  int n_valid = 0;
  int n_perr = 0;
  int n_serr = 0;
  int multi = 0;
  int busy_bad = 0;
  logic prev_busy = 1'b0;
  logic [W-1:0] got_q[$];

  // Reference model state
  int exp_valid = 0;
  int exp_perr = 0;
  int exp_serr = 0;
  logic [W-1:0] exp_data = '0;
  logic [W-1:0] exp_q[$];

  // Monitor: sample outputs on the falling edge, away from the active edge
  always @(negedge CLK_RX) begin
    if (DATA_VALID_RX) begin
      n_valid++;
      got_q.push_back(P_DATA_RX);
    end
    if (PAR_ERR) n_perr++;
    if (STP_ERR) n_serr++;
    if ((int'(DATA_VALID_RX) + int'(PAR_ERR) + int'(STP_ERR)) > 1) multi++;
    if ((DATA_VALID_RX || PAR_ERR || STP_ERR) && (Busy || !prev_busy)) busy_bad++;
    prev_busy = Busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK_RX);
      #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    cyc(n);
  endtask

  // One bit period; flip_at >= 0 inverts the line for that single cycle
  task automatic drive_bit(input logic b, input int flip_at);
    for (int c = 0; c < P; c++) begin
      RX_IN = (c == flip_at) ? ~b : b;
      cyc(1);
    end
  endtask

  // Parity bit that makes the frame satisfy the chosen parity type
  function automatic logic good_parity(input logic [W-1:0] d, input logic ptyp);
    logic odd_ones;
    odd_ones = ($countones(d) % 2) == 1;
    return (ptyp == PAR_ODD) ? !odd_ones : odd_ones;
  endfunction

  task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stop_v, input int flip_bit);
    logic [W-1:0] dv;
    dv = d;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    drive_bit(1'b0, -1);
    // The receiver has latched its config by now; scramble it to prove that
    PAR_EN  = 1'($urandom_range(0, 1));
    PAR_TYP = 1'($urandom_range(0, 1));
    for (int i = 0; i < W; i++) begin
      drive_bit(dv[i], (i == flip_bit) ? (P / 2) + 1 : -1);
    end
    if (pen) drive_bit(good_parity(d, ptyp) ^ bad_par, -1);
    drive_bit(stop_v, -1);
    RX_IN = 1'b1;
    if (!stop_v) begin
      exp_serr++;
    end else if (pen && bad_par) begin
      exp_perr++;
    end else begin
      exp_valid++;
      exp_data = d;
      exp_q.push_back(d);
    end
  endtask

  task automatic settle(input string tag);
    idle(3 * P);
    check({tag, " valid_cnt"}, n_valid, exp_valid);
    check({tag, " par_err_cnt"}, n_perr, exp_perr);
    check({tag, " stp_err_cnt"}, n_serr, exp_serr);
    check({tag, " p_data"}, 32'(P_DATA_RX), 32'(exp_data));
    check({tag, " busy_idle"}, 32'(Busy), 32'd0);
    check({tag, " exclusive"}, multi, 0);
    check({tag, " busy_edge"}, busy_bad, 0);
    check({tag, " word_cnt"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, " word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [W-1:0] c3;
    c3 = 8'hC3;

    // Reset
    RST_RX = 1'b0;
    cyc(3);
    check("rst p_data", 32'(P_DATA_RX), 32'd0);
    check("rst valid", 32'(DATA_VALID_RX), 32'd0);
    check("rst par_err", 32'(PAR_ERR), 32'd0);
    check("rst stp_err", 32'(STP_ERR), 32'd0);
    check("rst busy", 32'(Busy), 32'd0);
    RST_RX = 1'b1;
    idle(2 * P);
    check("post_rst busy", 32'(Busy), 32'd0);

    // Good frame with even parity
    send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1);
    settle("a5");

    // Back-to-back: no parity, then odd parity
    send_frame(8'hF4, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    send_frame(8'hF2, 1'b1, PAR_ODD, 1'b0, 1'b1, -1);
    settle("b2b");

    // Parity error keeps the previous word
    send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1);
    settle("perr");

    // Stop error, then recovery
    send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1);
    settle("serr");
    send_frame(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    settle("recover");

    // Break: line held low across two frame times, each must end in a stop error
    send_frame(8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1);
    send_frame(8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1);
    settle("break");
    send_frame(8'h96, 1'b1, PAR_ODD, 1'b0, 1'b1, -1);
    settle("post_break");

    // Short low glitch on an idle line
    RX_IN = 1'b0;
    cyc(2);
    settle("glitch");

    // Reset during data bit 4 of 0xC3
    PAR_EN = 1'b0;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], -1);
    RX_IN = c3[4];
    cyc(P / 2);
    RST_RX = 1'b0;
    RX_IN  = 1'b1;
    cyc(3);
    RST_RX = 1'b1;
    exp_data = '0;
    settle("abort");
    send_frame(8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    settle("after_abort");

    // Single-cycle mid-bit flips must be voted out
    send_frame(8'h0F, 1'b0, PAR_EVEN, 1'b0, 1'b1, 2);
    send_frame(8'h0F, 1'b1, PAR_EVEN, 1'b0, 1'b1, 5);
    settle("majority");

    // Randomized frames in groups, with random gaps (zero gap = back-to-back)
    for (int g = 0; g < 6; g++) begin
      for (int f = 0; f < 5; f++) begin
        logic [W-1:0] d;
        logic pen, ptyp, bad_par, stop_v;
        int kind, flip;
        d       = W'($urandom);
        pen     = 1'($urandom_range(0, 1));
        ptyp    = 1'($urandom_range(0, 1));
        kind    = $urandom_range(0, 5);
        bad_par = (kind == 4);
        stop_v  = (kind != 5);
        flip    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W - 1) : -1;
        send_frame(d, pen, ptyp, bad_par, stop_v, flip);
        idle($urandom_range(0, 2 * P));
      end
      settle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
